// File: rtl/la_debounce.sv
// Synchronizing glitch filter and edge detector for N independent single-bit inputs.
// Each channel passes through a STAGES-deep synchronizer, then a per-channel counter
// that accepts a new level only after DEPTH consecutive differing samples.
module la_debounce #(
  parameter int unsigned    N      = 1,
  parameter int unsigned    STAGES = 2,
  parameter int unsigned    DEPTH  = 4,
  parameter logic [N-1:0]   RSTVAL = '0,
  parameter string          PROP   = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [N-1:0] z,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  // Counter only has to reach DEPTH-1; width matches the documented cnt width.
  localparam int unsigned    CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH - 1);

  // Reject unusable configurations at elaboration time.
  if (STAGES < 2 || DEPTH < 1 || PROP == "") begin : g_bad_params
    $error("la_debounce: invalid parameters (STAGES>=2, DEPTH>=1, PROP non-empty)");
  end

  logic [N-1:0]  r_sync [STAGES];
  logic [N-1:0]  w_s;
  logic [N-1:0]  r_z;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic [CW-1:0] r_cnt  [N];

  logic [N-1:0]  w_z_d;
  logic [N-1:0]  w_rise_d;
  logic [N-1:0]  w_fall_d;
  logic [CW-1:0] w_cnt_d [N];

  assign w_s  = r_sync[STAGES-1];
  assign z    = r_z;
  assign rise = r_rise;
  assign fall = r_fall;

  // Synchronizer chain; runs independently of en so s always tracks the pins.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned st = 0; st < STAGES; st++) begin
        r_sync[st] <= RSTVAL;
      end
    end else begin
      r_sync[0] <= in;
      for (int unsigned st = 1; st < STAGES; st++) begin
        r_sync[st] <= r_sync[st-1];
      end
    end
  end

  // Per-channel filter: count consecutive differing samples, commit on the DEPTH-th.
  always_comb begin
    w_z_d    = r_z;
    w_rise_d = '0;
    w_fall_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_cnt_d[i] = r_cnt[i];
    end
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_s[i] == r_z[i]) begin
          w_cnt_d[i] = '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          // New level accepted; the pulse lands on the same edge as the new z.
          w_z_d[i]    = w_s[i];
          w_cnt_d[i]  = '0;
          w_rise_d[i] = w_s[i];
          w_fall_d[i] = ~w_s[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Filter state and edge pulses; reset drops any partial count or pending pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_z    <= RSTVAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_z    <= w_z_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
      for (int unsigned i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_la_debounce.sv
// Directed bench for la_debounce (N=2, STAGES=2, DEPTH=4) plus a DEPTH=1 instance.
// Edges are counted from E = first rising edge after an input change (tick 1 = E),
// so a commit at E+5 is observed after the 6th tick.
module tb_la_debounce;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       nreset = 1'b1;
  logic       en     = 1'b1;
  logic [1:0] in     = 2'b11;
  logic [1:0] z, rise, fall;
  logic       z1, rise1, fall1;

  int checks = 0;
  int errors = 0;

  la_debounce #(
    .N(2), .STAGES(2), .DEPTH(4), .RSTVAL(2'b00), .PROP("DEFAULT")
  ) u_dut (
    .clk(clk), .nreset(nreset), .en(en), .in(in), .z(z), .rise(rise), .fall(fall)
  );

  la_debounce #(
    .N(1), .STAGES(2), .DEPTH(1), .RSTVAL(1'b0), .PROP("DEFAULT")
  ) u_dut1 (
    .clk(clk), .nreset(nreset), .en(en), .in(in[0]), .z(z1), .rise(rise1), .fall(fall1)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({z, rise, fall} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL reset_async: got z=%b rise=%b fall=%b, required 00 00 00", z, rise, fall);
    end
    checks++;
    if ({z1, rise1, fall1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async_d1: got %b%b%b, required 000", z1, rise1, fall1);
    end
    clk_en = 1'b1;
    tick();
    tick();
    nreset = 1'b1;
    repeat (5) tick();
    checks++;
    if ({z, rise, fall} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL reset_latency_early: got z=%b rise=%b fall=%b, required 00 00 00",
               z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_11_00) begin
      errors++;
      $display("FAIL reset_latency_commit: got z=%b rise=%b fall=%b, required 11 11 00",
               z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL reset_rise_one_cycle: got z=%b rise=%b fall=%b, required 11 00 00",
               z, rise, fall);
    end
  endtask

  task automatic test_edge();
    in = 2'b10;
    repeat (5) tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL edge_fall_early: got z=%b rise=%b fall=%b, required 11 00 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_01) begin
      errors++;
      $display("FAIL edge_fall_commit: got z=%b rise=%b fall=%b, required 10 00 01", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL edge_fall_clear: got z=%b rise=%b fall=%b, required 10 00 00", z, rise, fall);
    end
    repeat (3) tick();
    in = 2'b11;
    repeat (5) tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL edge_rise_early: got z=%b rise=%b fall=%b, required 10 00 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_01_00) begin
      errors++;
      $display("FAIL edge_rise_commit: got z=%b rise=%b fall=%b, required 11 01 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL edge_rise_clear: got z=%b rise=%b fall=%b, required 11 00 00", z, rise, fall);
    end
  endtask

  task automatic test_glitch();
    in = 2'b10;
    repeat (8) tick();
    // Three high samples: counter reaches 3 but never commits.
    in = 2'b11;
    repeat (3) tick();
    in = 2'b10;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({z, rise, fall} !== 6'b10_00_00) begin
        errors++;
        $display("FAIL glitch3_reject[%0d]: got z=%b rise=%b fall=%b, required 10 00 00",
                 k, z, rise, fall);
      end
    end
    // Exactly four high samples: accepted, then four low samples fall back.
    in = 2'b11;
    repeat (4) tick();
    in = 2'b10;
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL glitch4_early: got z=%b rise=%b fall=%b, required 10 00 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_01_00) begin
      errors++;
      $display("FAIL glitch4_rise: got z=%b rise=%b fall=%b, required 11 01 00", z, rise, fall);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({z, rise, fall} !== 6'b11_00_00) begin
        errors++;
        $display("FAIL glitch4_hold[%0d]: got z=%b rise=%b fall=%b, required 11 00 00",
                 k, z, rise, fall);
      end
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_01) begin
      errors++;
      $display("FAIL glitch4_fall: got z=%b rise=%b fall=%b, required 10 00 01", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL glitch4_fall_clear: got z=%b rise=%b fall=%b, required 10 00 00",
               z, rise, fall);
    end
  endtask

  task automatic test_enable();
    in = 2'b10;
    repeat (8) tick();
    in = 2'b11;
    repeat (4) tick();
    // Two differing samples counted; freeze with the count pending.
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({z, rise, fall} !== 6'b10_00_00) begin
        errors++;
        $display("FAIL enable_freeze[%0d]: got z=%b rise=%b fall=%b, required 10 00 00",
                 k, z, rise, fall);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL enable_resume1: got z=%b rise=%b fall=%b, required 10 00 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_01_00) begin
      errors++;
      $display("FAIL enable_resume2: got z=%b rise=%b fall=%b, required 11 01 00", z, rise, fall);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL enable_pulse_clear: got z=%b rise=%b fall=%b, required 11 00 00",
               z, rise, fall);
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    in = 2'b11;
    repeat (8) tick();
    in = 2'b10;
    repeat (5) tick();
    checks++;
    if ({z, rise, fall} !== 6'b11_00_00) begin
      errors++;
      $display("FAIL rstmid_pre: got z=%b rise=%b fall=%b, required 11 00 00", z, rise, fall);
    end
    #1 nreset = 1'b0;
    #1;
    checks++;
    if ({z, rise, fall} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL rstmid_async: got z=%b rise=%b fall=%b, required 00 00 00", z, rise, fall);
    end
    #1 nreset = 1'b1;
    repeat (5) tick();
    checks++;
    if ({z, rise, fall} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL rstmid_early: got z=%b rise=%b fall=%b, required 00 00 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_10_00) begin
      errors++;
      $display("FAIL rstmid_commit: got z=%b rise=%b fall=%b, required 10 10 00", z, rise, fall);
    end
    tick();
    checks++;
    if ({z, rise, fall} !== 6'b10_00_00) begin
      errors++;
      $display("FAIL rstmid_clear: got z=%b rise=%b fall=%b, required 10 00 00", z, rise, fall);
    end
  endtask

  task automatic test_toggle();
    in = 2'b10;
    repeat (8) tick();
    for (int k = 0; k < 50; k++) begin
      in = in ^ 2'b11;
      tick();
      checks++;
      if ({z, rise, fall} !== 6'b10_00_00) begin
        errors++;
        $display("FAIL toggle[%0d]: got z=%b rise=%b fall=%b, required 10 00 00",
                 k, z, rise, fall);
      end
    end
  endtask

  task automatic test_depth1();
    in = 2'b11;
    repeat (4) tick();
    in = 2'b10;
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b100) begin
      errors++;
      $display("FAIL d1_hold: got z=%b rise=%b fall=%b, required 1 0 0", z1, rise1, fall1);
    end
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b100) begin
      errors++;
      $display("FAIL d1_pre: got z=%b rise=%b fall=%b, required 1 0 0", z1, rise1, fall1);
    end
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b001) begin
      errors++;
      $display("FAIL d1_fall: got z=%b rise=%b fall=%b, required 0 0 1", z1, rise1, fall1);
    end
    // Single-cycle high: with DEPTH=1 it passes straight through.
    in = 2'b11;
    tick();
    in = 2'b10;
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b000) begin
      errors++;
      $display("FAIL d1_low: got z=%b rise=%b fall=%b, required 0 0 0", z1, rise1, fall1);
    end
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b110) begin
      errors++;
      $display("FAIL d1_rise: got z=%b rise=%b fall=%b, required 1 1 0", z1, rise1, fall1);
    end
    tick();
    checks++;
    if ({z1, rise1, fall1} !== 3'b001) begin
      errors++;
      $display("FAIL d1_fall2: got z=%b rise=%b fall=%b, required 0 0 1", z1, rise1, fall1);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_toggle();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
